// File: rtl/wb_store_queue.sv
// wb_store_queue: in-order store buffer between writeback and the mem stage.
// Committed stores are queued here and issued one per cycle to the mem
// stage's writeback port. This keeps writeback running while the D$
// write-address queue is applying backpressure.
module wb_store_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             st_valid,
  input  logic [63:0]      st_data,
  input  logic [31:0]      st_addr,
  input  logic [1:0]       st_size,
  input  logic [6:0]       st_ptcid,
  output logic             st_stall,
  input  logic             wbaq_isfull,
  output logic             wb_valid,
  output logic [63:0]      wb_memdata,
  output logic [31:0]      wb_memaddr,
  output logic [1:0]       wb_size,
  output logic [6:0]       wb_ptcid,
  output logic             sq_empty,
  output logic [PTR_W:0]   sq_count,
  output logic             sq_overflow
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Entry storage; deliberately left unreset, since validity is tracked by count.
  logic [63:0]      data_mem  [DEPTH];
  logic [31:0]      addr_mem  [DEPTH];
  logic [1:0]       size_mem  [DEPTH];
  logic [6:0]       ptcid_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             overflow;

  logic             full;
  logic             nonempty;
  logic             push;
  logic             pop;

  // Pointer advance with an explicit wrap at the last slot.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Full/empty are decoded from the registered count. Pointer equality is
  // ambiguous, and a same-cycle pop does not make room for a push.
  assign full     = (count == FULL_CNT);
  assign nonempty = (count != '0);
  assign push     = st_valid & ~full;
  assign pop      = nonempty & ~wbaq_isfull;

  // Occupancy update: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Control state: pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      count <= count_next;
      if (st_valid && full) overflow <= 1'b1;
    end
  end

  // Capture the incoming store at the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail]  <= st_data;
      addr_mem[tail]  <= st_addr;
      size_mem[tail]  <= st_size;
      ptcid_mem[tail] <= st_ptcid;
    end
  end

  // The head entry drives the mem port directly. The payload reads zero
  // when the queue is empty, so stale storage never shows up on the port.
  always_comb begin
    wb_memdata = '0;
    wb_memaddr = '0;
    wb_size    = '0;
    wb_ptcid   = '0;
    if (nonempty) begin
      wb_memdata = data_mem[head];
      wb_memaddr = addr_mem[head];
      wb_size    = size_mem[head];
      wb_ptcid   = ptcid_mem[head];
    end
  end

  assign wb_valid    = pop;
  assign st_stall    = full;
  assign sq_empty    = ~nonempty;
  assign sq_count    = count;
  assign sq_overflow = overflow;

endmodule

// File: tb/tb_wb_store_queue.sv
// Directed bench for wb_store_queue: a vector table for the fill, overflow,
// refused-push and stall-toggle sequences, plus hand-written sequences for
// the first-store latency, continuous streaming and asynchronous reset.
module tb_wb_store_queue;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        st_valid = 1'b0;
  logic [63:0] st_data = '0;
  logic [31:0] st_addr = '0;
  logic [1:0]  st_size = '0;
  logic [6:0]  st_ptcid = '0;
  logic        st_stall;
  logic        wbaq_isfull = 1'b0;
  logic        wb_valid;
  logic [63:0] wb_memdata;
  logic [31:0] wb_memaddr;
  logic [1:0]  wb_size;
  logic [6:0]  wb_ptcid;
  logic        sq_empty;
  logic [3:0]  sq_count;
  logic        sq_overflow;

  int checks = 0;
  int failures = 0;

  wb_store_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .clr(clr),
    .st_valid(st_valid), .st_data(st_data), .st_addr(st_addr),
    .st_size(st_size), .st_ptcid(st_ptcid), .st_stall(st_stall),
    .wbaq_isfull(wbaq_isfull), .wb_valid(wb_valid),
    .wb_memdata(wb_memdata), .wb_memaddr(wb_memaddr),
    .wb_size(wb_size), .wb_ptcid(wb_ptcid),
    .sq_empty(sq_empty), .sq_count(sq_count), .sq_overflow(sq_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;   // st_valid
    logic [31:0] a;   // st_addr
    logic        f;   // wbaq_isfull
    logic        ev;  // expected wb_valid
    logic [31:0] ea;  // expected wb_memaddr when ev
    logic [3:0]  ec;  // expected sq_count
    logic        es;  // expected st_stall
    logic        eo;  // expected sq_overflow
  } vec_t;

  vec_t vq[$];

  // Payload fields are derived from the address so that an address check
  // also pins down data, size and ptcid.
  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a};
  endfunction
  function automatic logic [1:0] size_of(input logic [31:0] a);
    return a[1:0];
  endfunction
  function automatic logic [6:0] ptcid_of(input logic [31:0] a);
    return a[6:0] ^ 7'h2A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic f);
    st_valid    = v;
    st_addr     = a;
    st_data     = data_of(a);
    st_size     = size_of(a);
    st_ptcid    = ptcid_of(a);
    wbaq_isfull = f;
  endtask

  task automatic add(input logic v, input logic [31:0] a, input logic f, input logic ev,
                     input logic [31:0] ea, input logic [3:0] ec, input logic es, input logic eo);
    vq.push_back('{v: v, a: a, f: f, ev: ev, ea: ea, ec: ec, es: es, eo: eo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    #2;
    chk("rst st_stall", st_stall, 0);
    chk("rst sq_empty", sq_empty, 1);
    chk("rst sq_count", sq_count, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_memdata", wb_memdata, 0);
    chk("rst wb_memaddr", wb_memaddr, 0);
    chk("rst sq_overflow", sq_overflow, 0);
    tick();

    // ---------------- single store, one-cycle latency ----------------
    st_valid = 1'b1; st_data = 64'h1122334455667788; st_addr = 32'h0000_1000;
    st_size = 2'b11; st_ptcid = 7'h05; wbaq_isfull = 1'b0;
    #2;
    chk("t1 no bypass wb_valid", wb_valid, 0);
    tick();
    st_valid = 1'b0;
    #2;
    chk("t1 wb_valid", wb_valid, 1);
    chk("t1 wb_memdata", wb_memdata, 64'h1122334455667788);
    chk("t1 wb_memaddr", wb_memaddr, 32'h0000_1000);
    chk("t1 wb_size", wb_size, 2'b11);
    chk("t1 wb_ptcid", wb_ptcid, 7'h05);
    chk("t1 sq_count", sq_count, 1);
    tick();
    #2;
    chk("t1 drained sq_empty", sq_empty, 1);
    chk("t1 drained wb_valid", wb_valid, 0);
    chk("t1 drained wb_memdata", wb_memdata, 0);
    tick();

    // ---------------- vector table ----------------
    // Fill 8 while frozen, then a 9th push overflows, then drain in order.
    for (int k = 0; k < 8; k++)
      add(1, 32'h100 + k, 1, 0, 0, 4'(k), 0, 0);
    add(1, 32'h108, 1, 0, 0, 8, 1, 0);
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 1, 32'h100 + k, 4'(8 - k), (k == 0), 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Refill to 8; a push during a pop at full is refused, then accepted.
    for (int k = 0; k < 8; k++)
      add(1, 32'h200 + k, 1, 0, 0, 4'(k), 0, 1);
    add(1, 32'h208, 0, 1, 32'h200, 8, 1, 1);
    add(1, 32'h208, 0, 1, 32'h201, 7, 0, 1);
    add(0, 0, 0, 1, 32'h202, 7, 0, 1);
    for (int k = 3; k <= 8; k++)
      add(0, 0, 0, 1, 32'h200 + k, 4'(9 - k), 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Four held entries with wbaq_isfull toggling: one issue per low cycle.
    for (int k = 0; k < 4; k++)
      add(1, 32'h300 + k, 1, 0, 0, 4'(k), 0, 1);
    for (int k = 0; k < 4; k++) begin
      add(0, 0, 1, 0, 0, 4'(4 - k), 0, 1);
      add(0, 0, 0, 1, 32'h300 + k, 4'(4 - k), 0, 1);
    end
    add(0, 0, 1, 0, 0, 0, 0, 1);

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].a, vq[i].f);
      #2;
      chk($sformatf("v%0d wb_valid", i), wb_valid, vq[i].ev);
      chk($sformatf("v%0d sq_count", i), sq_count, vq[i].ec);
      chk($sformatf("v%0d st_stall", i), st_stall, vq[i].es);
      chk($sformatf("v%0d sq_overflow", i), sq_overflow, vq[i].eo);
      chk($sformatf("v%0d sq_empty", i), sq_empty, (vq[i].ec == 0));
      if (vq[i].ev) begin
        chk($sformatf("v%0d wb_memaddr", i), wb_memaddr, vq[i].ea);
        chk($sformatf("v%0d wb_memdata", i), wb_memdata, data_of(vq[i].ea));
        chk($sformatf("v%0d wb_size", i), wb_size, size_of(vq[i].ea));
        chk($sformatf("v%0d wb_ptcid", i), wb_ptcid, ptcid_of(vq[i].ea));
      end
      tick();
    end

    // ---------------- continuous streaming across pointer wraps ----------------
    for (int k = 0; k < 22; k++) begin
      drive(k < 20, 32'h400 + k, 0);
      #2;
      chk($sformatf("s%0d wb_valid", k), wb_valid, (k >= 1 && k <= 20));
      chk($sformatf("s%0d sq_count", k), sq_count, (k >= 1 && k <= 20) ? 1 : 0);
      if (k >= 1 && k <= 20) begin
        chk($sformatf("s%0d wb_memaddr", k), wb_memaddr, 32'h400 + k - 1);
        chk($sformatf("s%0d wb_memdata", k), wb_memdata, data_of(32'h400 + k - 1));
      end
      tick();
    end

    // ---------------- asynchronous reset with entries held ----------------
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h500 + k, 1);
      tick();
    end
    drive(0, 0, 0);
    #1;
    chk("ar pre sq_count", sq_count, 5);
    chk("ar pre wb_valid", wb_valid, 1);
    #1 clr = 1'b0;
    #1;
    chk("ar sq_count", sq_count, 0);
    chk("ar sq_empty", sq_empty, 1);
    chk("ar wb_valid", wb_valid, 0);
    chk("ar wb_memaddr", wb_memaddr, 0);
    chk("ar sq_overflow", sq_overflow, 0);
    tick();
    #1 clr = 1'b1;
    tick();
    #2;
    chk("ar post wb_valid", wb_valid, 0);
    chk("ar post sq_count", sq_count, 0);
    tick();
    drive(1, 32'h600, 0);
    #2;
    chk("ar new push wb_valid", wb_valid, 0);
    tick();
    drive(0, 0, 0);
    #2;
    chk("ar new wb_valid", wb_valid, 1);
    chk("ar new wb_memaddr", wb_memaddr, 32'h600);
    chk("ar new sq_count", sq_count, 1);
    tick();
    #2;
    chk("ar new drained", sq_empty, 1);
    chk("ar no stale issue", wb_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
